boot_loader: RTL and testbench

Program loader that sits directly upstream of `risc_v_core`'s instruction memory. It receives a framed byte stream from a UART receiver, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory. The core is held in reset until a complete, valid image has been written.

---
 rtl/boot_loader_pkg.sv | 27 ++
 rtl/boot_loader_word_assembler.sv | 34 +++
 rtl/boot_loader.sv | 187 ++++++++++++++++++
 tb/tb_boot_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared state encoding, default sync marker and helpers
// for the UART boot loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } bl_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Word capacity of an instruction memory with the given byte-address width.
  function automatic int max_words(input int addr_width);
    return (32'sd1 <<< addr_width) / 32'sd4;
  endfunction

  // Running 8-bit modular sum used for the image checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/boot_loader_word_assembler.sv
// word_assembler: collects four bytes, least significant first, into a
// 32-bit word. word/word_ready are valid combinationally in the cycle the
// fourth byte is presented so the parent can register the write directly.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [23:0] shift_r;
  logic [1:0]  cnt_r;

  // Shift earlier bytes down so the first byte ends in the low lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= 24'd0;
      cnt_r   <= 2'd0;
    end else if (clr) begin
      shift_r <= 24'd0;
      cnt_r   <= 2'd0;
    end else if (byte_valid) begin
      shift_r <= {byte_in, shift_r[23:8]};
      cnt_r   <= cnt_r + 2'd1;
    end
  end

  assign word       = {byte_in, shift_r};
  assign word_ready = byte_valid && (cnt_r == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// boot_loader: parses a framed UART byte stream (sync, 16-bit word count,
// little-endian words) and writes the words sequentially into instruction
// memory, holding the core in reset until a complete image is present.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN adds a trailing 8-bit
// sum-of-data-bytes check before the image is accepted.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 10,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  instr_we,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic [31:0]           instr_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH-2:0] words_loaded
);

  localparam int MAX_WORDS = max_words(ADDR_WIDTH);
  localparam int IW        = ADDR_WIDTH - 1;
  localparam int TO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  bl_state_t       state_r, state_s;
  logic [7:0]      len_lo_r;
  logic [15:0]     len_r;
  logic [15:0]     len_s;
  logic [IW-1:0]   idx_r, idx_s;
  logic [TO_W-1:0] to_cnt_r;
  logic            active_s, timeout_s, sync_acc_s, len_bad_s;
  logic            data_byte_s, last_word_s;
  logic            word_ready_s;
  logic [31:0]     word_s;
  logic            we_s, hold_s, done_s, err_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [31:0]     wdata_s;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]      csum_r;
`endif

  assign len_s       = {rx_data, len_lo_r};
  assign active_s    = (state_r == ST_LEN_LO) || (state_r == ST_LEN_HI) ||
                       (state_r == ST_DATA)   || (state_r == ST_CSUM);
  assign timeout_s   = active_s && !rx_valid && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
  assign sync_acc_s  = rx_valid && (rx_data == SYNC_BYTE) &&
                       ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));
  assign len_bad_s   = (len_s == 16'd0) || (int'({16'd0, len_s}) > MAX_WORDS);
  assign data_byte_s = rx_valid && (state_r == ST_DATA);
  assign last_word_s = (int'(idx_r) + 32'sd1) == int'({16'd0, len_r});

  word_assembler u_asm (
    .clk        (CLOCK_50),
    .reset      (reset),
    .clr        (sync_acc_s),
    .byte_valid (data_byte_s),
    .byte_in    (rx_data),
    .word       (word_s),
    .word_ready (word_ready_s)
  );

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // FSM next-state decode; an idle-gap timeout in any in-frame state aborts.
  always_comb begin
    state_s = state_r;
    if (timeout_s) begin
      state_s = ST_ERROR;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (sync_acc_s) state_s = ST_LEN_LO;
          else            state_s = state_r;
        end
        ST_LEN_LO: begin
          if (rx_valid) state_s = ST_LEN_HI;
          else          state_s = state_r;
        end
        ST_LEN_HI: begin
          if (rx_valid) state_s = len_bad_s ? ST_ERROR : ST_DATA;
          else          state_s = state_r;
        end
        ST_DATA: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          if (word_ready_s && last_word_s) state_s = ST_CSUM;
          else                             state_s = state_r;
`else
          if (word_ready_s && last_word_s) state_s = ST_DONE;
          else                             state_s = state_r;
`endif
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (rx_valid) state_s = (rx_data == csum_r) ? ST_DONE : ST_ERROR;
          else          state_s = state_r;
        end
`endif
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Word index: restarts with each frame, advances on every assembled word.
  always_comb begin
    idx_s = idx_r;
    if (sync_acc_s || (rx_valid && (state_r == ST_LEN_HI))) idx_s = '0;
    else if (word_ready_s)                                  idx_s = idx_r + 1'b1;
    else                                                    idx_s = idx_r;
  end

  // FSM output decode: next values of the registered outputs.
  always_comb begin
    we_s    = word_ready_s;
    hold_s  = (state_s != ST_DONE);
    done_s  = (state_s == ST_DONE);
    err_s   = (state_s == ST_ERROR);
    addr_s  = instr_addr;
    wdata_s = instr_wdata;
    if (word_ready_s) begin
      addr_s  = {idx_r[ADDR_WIDTH-3:0], 2'b00};
      wdata_s = word_s;
    end else begin
      addr_s  = instr_addr;
      wdata_s = instr_wdata;
    end
  end

  // Output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      instr_we     <= 1'b0;
      instr_addr   <= '0;
      instr_wdata  <= 32'd0;
      core_hold    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      instr_we     <= we_s;
      instr_addr   <= addr_s;
      instr_wdata  <= wdata_s;
      core_hold    <= hold_s;
      load_done    <= done_s;
      load_error   <= err_s;
      words_loaded <= idx_s;
    end
  end

  // Frame datapath: length capture, word index and inter-byte timeout.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      len_lo_r <= 8'd0;
      len_r    <= 16'd0;
      idx_r    <= '0;
      to_cnt_r <= '0;
    end else begin
      if (rx_valid && (state_r == ST_LEN_LO)) len_lo_r <= rx_data;
      if (rx_valid && (state_r == ST_LEN_HI)) len_r    <= len_s;
      idx_r <= idx_s;
      if (rx_valid || !active_s) to_cnt_r <= '0;
      else                       to_cnt_r <= to_cnt_r + 1'b1;
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  // Checksum accumulator over every data byte of the current frame.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      csum_r <= 8'd0;
    end else if (sync_acc_s || (rx_valid && (state_r == ST_LEN_HI))) begin
      csum_r <= 8'd0;
    end else if (data_byte_s) begin
      csum_r <= csum_add(csum_r, rx_data);
    end
  end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frames against boot_loader with a write
// scoreboard (expected memory writes queued by the stimulus, popped by a
// monitor on every instr_we) plus direct status checks after each byte.
module tb_boot_loader;

  localparam int AW = 10;
  localparam int TO = 16;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          instr_we;
  logic [AW-1:0] instr_addr;
  logic [31:0]   instr_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_error;
  logic [AW-2:0] words_loaded;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         writes_seen = 0;
  logic [7:0] sum_acc;
  int         w0;

  boot_loader #(
    .ADDR_WIDTH     (AW),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .instr_we     (instr_we),
    .instr_addr   (instr_addr),
    .instr_wdata  (instr_wdata),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge CLOCK_50) begin
    if (instr_we === 1'b1) begin
      wr_t e;
      writes_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", instr_addr, instr_wdata);
      end else begin
        e = exp_q.pop_front();
        if (instr_addr !== e.addr || instr_wdata !== e.data) begin
          fails++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   instr_addr, instr_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Queue the expected write and send the word LSB first, updating the sum.
  task automatic send_word(input logic [31:0] w, input int idx);
    wr_t e;
    e.addr = AW'(idx * 4);
    e.data = w;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = w[8*k +: 8];
      sum_acc = sum_acc + b;
      send(b);
    end
  endtask

  task automatic status(input string name, input logic hold, input logic done, input logic err);
    check({name, "_core_hold"}, {31'd0, core_hold}, {31'd0, hold});
    check({name, "_load_done"}, {31'd0, load_done}, {31'd0, done});
    check({name, "_load_error"}, {31'd0, load_error}, {31'd0, err});
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_we"}, {31'd0, instr_we}, 32'd0);
    check({name, "_addr"}, {22'd0, instr_addr}, 32'd0);
    check({name, "_wdata"}, instr_wdata, 32'd0);
    check({name, "_words"}, {23'd0, words_loaded}, 32'd0);
    status(name, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    sum_acc  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("reset");

    // Two-word frame.
    send(8'hA5); send(8'h02); send(8'h00);
    sum_acc = 8'h00;
    send_word(32'h0000_0013, 0);
    check("latency_we", {31'd0, instr_we}, 32'd1);
    check("latency_words", {23'd0, words_loaded}, 32'd1);
    send_word(32'h0010_0093, 1);
    check("sum_2word", {24'd0, sum_acc}, 32'h0000_00B6);
`ifdef BOOT_LOADER_CHECKSUM_EN
    status("await_csum", 1'b1, 1'b0, 1'b0);
    send(sum_acc);
`endif
    status("frame2_done", 1'b0, 1'b1, 1'b0);
    check("frame2_words", {23'd0, words_loaded}, 32'd2);
    send(8'hED);
    status("done_ignores", 1'b0, 1'b1, 1'b0);

    // Same frame, bad checksum byte.
    send(8'hA5);
    status("reload", 1'b1, 1'b0, 1'b0);
    send(8'h02); send(8'h00);
    sum_acc = 8'h00;
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 1);
    send(8'h00);
`ifdef BOOT_LOADER_CHECKSUM_EN
    status("bad_csum", 1'b1, 1'b0, 1'b1);
`else
    status("trailing_zero_ignored", 1'b0, 1'b1, 1'b0);
`endif
    send(8'hA5);
    status("sync_clears", 1'b1, 1'b0, 1'b0);

    // Length 0 and length 257 abort right after the length.
    w0 = writes_seen;
    send(8'h00); send(8'h00);
    status("len0", 1'b1, 1'b0, 1'b1);
    send(8'hA5);
    status("len0_cleared", 1'b1, 1'b0, 1'b0);
    send(8'h01); send(8'h01);
    status("len257", 1'b1, 1'b0, 1'b1);
    tick();
    check("len_err_no_writes", writes_seen - w0, 32'd0);

    // Full 256-word image, back to back.
    w0 = writes_seen;
    send(8'hA5); send(8'h00); send(8'h01);
    sum_acc = 8'h00;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      send_word({iv, ~iv, 8'h5A, iv ^ 8'h3C}, i);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(sum_acc);
`endif
    status("full_done", 1'b0, 1'b1, 1'b0);
    check("full_words", {23'd0, words_loaded}, 32'd256);
    tick();
    check("full_write_count", writes_seen - w0, 32'd256);

    // Timeout after 5 data bytes: one write, then abort exactly at expiry.
    w0 = writes_seen;
    send(8'hA5); send(8'h03); send(8'h00);
    sum_acc = 8'h00;
    send_word(32'hCAFE_F00D, 0);
    send(8'h77);
    repeat (TO - 1) tick();
    status("before_expiry", 1'b1, 1'b0, 1'b0);
    tick();
    status("timeout", 1'b1, 1'b0, 1'b1);
    repeat (4) tick();
    check("timeout_one_write", writes_seen - w0, 32'd1);

    // Bytes landing on the expiry cycle keep the frame alive.
    send(8'hA5); send(8'h01); send(8'h00);
    sum_acc = 8'h00;
    begin
      wr_t e;
      e.addr = '0;
      e.data = 32'h4433_2211;
      exp_q.push_back(e);
    end
    send(8'h11); send(8'h22);
    repeat (TO - 1) tick();
    send(8'h33);
    status("alive_at_expiry", 1'b1, 1'b0, 1'b0);
    repeat (TO - 1) tick();
    send(8'h44);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(8'hAA);
`endif
    status("alive_done", 1'b0, 1'b1, 1'b0);

    // Reset after 3 data bytes of word 1, then a fresh frame.
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h9A); send(8'hBC); send(8'hDE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("mid_reset");
    send(8'hA5); send(8'h01); send(8'h00);
    sum_acc = 8'h00;
    send_word(32'h1234_5678, 0);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(sum_acc);
`endif
    status("after_reset_done", 1'b0, 1'b1, 1'b0);
    check("after_reset_words", {23'd0, words_loaded}, 32'd1);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
